// File: rtl/gp_reg_wr_ctrl.sv
// Write/clear initiator for a bank of gp_reg registers: one request at a time,
// one-hot strobe, ack wait with timeout, single-cycle response with error flag.
module gp_reg_wr_ctrl #(
  parameter int unsigned PA_DATA = 32,
  parameter int unsigned PA_HL   = 2,
  parameter int unsigned PA_NREG = 8,
  parameter int unsigned PA_ADDR = 3,
  parameter int unsigned PA_TO   = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [PA_ADDR-1:0] req_addr,
  input  logic [PA_DATA-1:0] req_data,
  input  logic [PA_HL-1:0]   req_hl,
  input  logic               req_clr,
  output logic [PA_DATA-1:0] reg_data,
  output logic [PA_HL-1:0]   reg_hl_sel,
  output logic [PA_NREG-1:0] reg_wr,
  output logic [PA_NREG-1:0] reg_clr,
  input  logic [PA_NREG-1:0] reg_wr_ack,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [PA_ADDR-1:0] rsp_addr
);

  localparam int unsigned CW = $clog2(PA_TO);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CLRW  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state, state_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [PA_ADDR-1:0] addr_q, addr_d;
  logic [PA_NREG-1:0] sel_q, sel_d;
  logic               clr_q, clr_d;
  logic               bad_q, bad_d;
  logic               req_ready_d;
  logic [PA_DATA-1:0] reg_data_d;
  logic [PA_HL-1:0]   reg_hl_sel_d;
  logic [PA_NREG-1:0] reg_wr_d, reg_clr_d;
  logic               rsp_valid_d, rsp_err_d;
  logic [PA_ADDR-1:0] rsp_addr_d;
  logic               req_bad, ack_hit;

  assign req_bad = (32'(req_addr) >= PA_NREG);
  // sel_q is the latched one-hot target, so acks on other bits are masked out
  assign ack_hit = |(reg_wr_ack & sel_q);

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    addr_d       = addr_q;
    sel_d        = sel_q;
    clr_d        = clr_q;
    bad_d        = bad_q;
    req_ready_d  = req_ready;
    reg_data_d   = reg_data;
    reg_hl_sel_d = reg_hl_sel;
    reg_wr_d     = '0;
    reg_clr_d    = '0;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = rsp_err;
    rsp_addr_d   = rsp_addr;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d      = req_addr;
          clr_d       = req_clr;
          bad_d       = req_bad;
          sel_d       = req_bad ? '0 : (PA_NREG'(1) << req_addr);
          cnt_d       = '0;
          req_ready_d = 1'b0;
          state_d     = S_ISSUE;
          if (!req_clr) begin
            reg_data_d   = req_data;
            reg_hl_sel_d = req_hl;
          end
          if (!req_bad) begin
            if (req_clr) reg_clr_d = PA_NREG'(1) << req_addr;
            else         reg_wr_d  = PA_NREG'(1) << req_addr;
          end
        end
      end
      S_ISSUE: begin
        if (bad_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_addr_d  = addr_q;
          state_d     = S_DONE;
        end else if (clr_q) begin
          state_d = S_CLRW;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // An ack on the final count still counts as success
        if (ack_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_addr_d  = addr_q;
          state_d     = S_DONE;
        end else if (cnt == CW'(PA_TO - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_addr_d  = addr_q;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_CLRW: begin
        if (cnt == CW'(1)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_addr_d  = addr_q;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_DONE: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      sel_q      <= '0;
      clr_q      <= 1'b0;
      bad_q      <= 1'b0;
      req_ready  <= 1'b1;
      reg_data   <= '0;
      reg_hl_sel <= '0;
      reg_wr     <= '0;
      reg_clr    <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_addr   <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      clr_q      <= clr_d;
      bad_q      <= bad_d;
      req_ready  <= req_ready_d;
      reg_data   <= reg_data_d;
      reg_hl_sel <= reg_hl_sel_d;
      reg_wr     <= reg_wr_d;
      reg_clr    <= reg_clr_d;
      rsp_valid  <= rsp_valid_d;
      rsp_err    <= rsp_err_d;
      rsp_addr   <= rsp_addr_d;
    end
  end

endmodule

// File: tb/tb_gp_reg_wr_ctrl.sv
// Directed bench for gp_reg_wr_ctrl driving a small behavioural gp_reg bank
// (6 registers, so index 7 is out of range).
module tb_gp_reg_wr_ctrl;

  localparam int unsigned NREG = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_hl;
  logic        req_clr;
  logic [31:0] reg_data;
  logic [1:0]  reg_hl_sel;
  logic [NREG-1:0] reg_wr;
  logic [NREG-1:0] reg_clr;
  logic [NREG-1:0] reg_wr_ack = '0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [2:0]  rsp_addr;

  gp_reg_wr_ctrl #(.PA_DATA(32), .PA_HL(2), .PA_NREG(NREG), .PA_ADDR(3), .PA_TO(15)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_hl(req_hl), .req_clr(req_clr),
    .reg_data(reg_data), .reg_hl_sel(reg_hl_sel), .reg_wr(reg_wr), .reg_clr(reg_clr),
    .reg_wr_ack(reg_wr_ack),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_addr(rsp_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural gp_reg bank: data sampled one cycle after the strobe, ack one cycle later
  logic [31:0]     gpr [NREG];
  logic [NREG-1:0] s1 = '0, s2 = '0, c1 = '0;
  logic [NREG-1:0] ack_en = '1;
  int              stray_cyc = -1;
  int              stray_bit = 0;

  always @(posedge clk) begin
    s1 <= reg_wr;
    s2 <= s1;
    c1 <= reg_clr;
    reg_wr_ack <= (s2 & ack_en) | ((cyc == stray_cyc) ? (NREG'(1) << stray_bit) : '0);
    for (int i = 0; i < int'(NREG); i++) begin
      if (c1[i]) gpr[i] <= '0;
      else if (s1[i]) begin
        case (reg_hl_sel)
          2'b00: gpr[i] <= reg_data;
          2'b01: gpr[i][15:0]  <= reg_data[15:0];
          2'b10: gpr[i][31:16] <= reg_data[31:16];
          default: ;
        endcase
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [NREG-1:0] wr_or, clr_or;
  int              wr_n, clr_n, lat;
  logic            r_err;
  logic [2:0]      r_addr;

  // Issue one request, monitor strobes until the response, record its latency
  task automatic do_req(input logic [2:0] a, input logic [31:0] d, input logic [1:0] h,
                        input logic c);
    int acc;
    bit got;
    req_addr = a; req_data = d; req_hl = h; req_clr = c; req_valid = 1'b1;
    for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
    chk("ready_wait", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    acc = cyc;
    got = 0; wr_or = '0; clr_or = '0; wr_n = 0; clr_n = 0; lat = -1; r_err = 1'bx; r_addr = 'x;
    for (int i = 0; i < 40; i++) begin
      wr_or  |= reg_wr;
      clr_or |= reg_clr;
      if (reg_wr != '0)  wr_n++;
      if (reg_clr != '0) clr_n++;
      if (rsp_valid) begin
        got = 1; lat = cyc - acc; r_err = rsp_err; r_addr = rsp_addr;
        break;
      end
      @(negedge clk);
    end
    chk("rsp_seen", got, 1);
    @(negedge clk);
  endtask

  initial begin
    int bad_rsp;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_hl = '0; req_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_wr", reg_wr, 0);
    chk("rst_clr", reg_clr, 0);
    chk("rst_rsp", rsp_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    do_req(3'd3, 32'hDEADBEEF, 2'b00, 1'b0);
    chk("w3_strobe", wr_or, 6'h08);
    chk("w3_strobe_len", wr_n, 1);
    chk("w3_no_clr", clr_n, 0);
    chk("w3_lat", lat, 4);
    chk("w3_err", r_err, 0);
    chk("w3_addr", r_addr, 3);
    chk("w3_data", gpr[3], 32'hDEADBEEF);

    do_req(3'd5, 32'h12345678, 2'b00, 1'b0);
    chk("w5_full", gpr[5], 32'h12345678);
    do_req(3'd5, 32'hFFFF_AAAA, 2'b01, 1'b0);
    chk("w5_low", gpr[5], 32'h1234AAAA);
    chk("w5_low_err", r_err, 0);
    do_req(3'd5, 32'hBBBB_0000, 2'b10, 1'b0);
    chk("w5_high", gpr[5], 32'hBBBBAAAA);
    do_req(3'd5, 32'h0000_0000, 2'b11, 1'b0);
    chk("w5_none", gpr[5], 32'hBBBBAAAA);
    chk("w5_none_err", r_err, 0);
    chk("w5_none_lat", lat, 4);

    do_req(3'd5, 32'h0, 2'b00, 1'b1);
    chk("c5_strobe", clr_or, 6'h20);
    chk("c5_strobe_len", clr_n, 1);
    chk("c5_no_wr", wr_n, 0);
    chk("c5_lat", lat, 3);
    chk("c5_err", r_err, 0);
    chk("c5_data", gpr[5], 0);

    // Timeout on reg 2 with a stray ack on reg 1 mid-wait
    ack_en = 6'b111011;
    stray_bit = 1; stray_cyc = cyc + 6;
    do_req(3'd2, 32'h11112222, 2'b00, 1'b0);
    chk("to_lat", lat, 16);
    chk("to_err", r_err, 1);
    chk("to_addr", r_addr, 2);

    // Ack seen on the very edge the count expires: success
    stray_bit = 2; stray_cyc = cyc + 15;
    do_req(3'd2, 32'h33334444, 2'b00, 1'b0);
    chk("edge_lat", lat, 16);
    chk("edge_err", r_err, 0);
    stray_cyc = -1;
    ack_en = '1;

    do_req(3'd7, 32'h55556666, 2'b00, 1'b0);
    chk("bad_no_wr", wr_n, 0);
    chk("bad_no_clr", clr_n, 0);
    chk("bad_lat", lat, 1);
    chk("bad_err", r_err, 1);
    chk("bad_addr", r_addr, 7);

    // Reset while waiting for the ack of reg 4
    req_addr = 3'd4; req_data = 32'hCAFEF00D; req_hl = 2'b00; req_clr = 1'b0; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_wr", reg_wr, 0);
    bad_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid || reg_wr != '0 || reg_clr != '0) bad_rsp++;
      @(negedge clk);
    end
    chk("mid_rst_quiet", bad_rsp, 0);

    do_req(3'd4, 32'h0BADC0DE, 2'b00, 1'b0);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_err", r_err, 0);
    chk("post_rst_data", gpr[4], 32'h0BADC0DE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
